mouse_tracker_bus: RTL and testbench

Parametrised successor to the fixed 160x120 mouse position logic. It accepts decoded PS/2 packets from the master state machine over a valid/ready handshake and buffers them in a small FIFO. Each packet is processed through an overflow/sign, sensitivity-shift and clamp-or-wrap pipeline into COORD_W-bit X/Y positions. Positions are exposed on the shared 8-bit memory-mapped bus with a read/write control register, and each update raises an interrupt held until acknowledged.

---
 rtl/mouse_tracker_bus.sv | 254 +++++++++++++++++++++++++
 tb/tb_mouse_tracker_bus.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_tracker_bus.sv
// PS/2 packet tracker: FIFO-buffered packets drive clamped/wrapped X/Y positions exposed on an 8-bit bus.
// Optional wheel accumulator (offset 6) enabled by defining MOUSE_WHEEL_EN.
module mouse_tracker_bus #(
    parameter int unsigned COORD_W    = 10,
    parameter int unsigned LIMIT_X    = 160,
    parameter int unsigned LIMIT_Y    = 120,
    parameter logic [7:0]  BASE_ADDR  = 8'hA0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WRAP_MODE  = 0,
    parameter int unsigned Y_INVERT   = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               PKT_VALID,
    output logic               PKT_READY,
    input  logic [7:0]         PKT_STATUS,
    input  logic [7:0]         PKT_DX,
    input  logic [7:0]         PKT_DY,
    input  logic [7:0]         PKT_DZ,
    input  logic [7:0]         BUS_ADDR,
    inout  wire  [7:0]         BUS_DATA,
    input  logic               BUS_WE,
    output logic [COORD_W-1:0] MOUSE_X,
    output logic [COORD_W-1:0] MOUSE_Y,
    output logic [3:0]         MOUSE_STATUS,
    output logic               MOUSE_INTERRUPT_RAISE,
    input  logic               MOUSE_INTERRUPT_ACK
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = COORD_W + 2;
    localparam logic [COORD_W-1:0]   X_CTR = COORD_W'(LIMIT_X / 2);
    localparam logic [COORD_W-1:0]   Y_CTR = COORD_W'(LIMIT_Y / 2);
    localparam logic signed [DW-1:0] X_LIM = DW'(LIMIT_X);
    localparam logic signed [DW-1:0] Y_LIM = DW'(LIMIT_Y);
    localparam logic signed [DW-1:0] X_MAX = DW'(LIMIT_X - 1);
    localparam logic signed [DW-1:0] Y_MAX = DW'(LIMIT_Y - 1);

    typedef struct packed {
`ifdef MOUSE_WHEEL_EN
        logic [7:0] dz;
`endif
        logic [7:0] status;
        logic [7:0] dx;
        logic [7:0] dy;
    } pkt_t;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CALC = 2'd2, UPDATE = 2'd3} state_t;

    state_t              state_q, state_d;
    pkt_t                mem [FIFO_DEPTH];
    pkt_t                pkt_in, pkt_q;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                push_c, pop_c, drop_c, upd_c;
    logic signed [DW-1:0] dx_q, dy_q;
    logic [1:0]          sens_q;
    logic                ovf_q;
    logic                hit_c, ctrl_wr_c, recenter_c, ovf_clr_c, rd_en_q;
    logic [3:0]          off_c;
    logic [7:0]          rd_mux_c, rd_data_q, wheel_val_c;
    logic [COORD_W-1:0]  y_bus_c;
    logic                unused_bus_hi;

    // Sign/magnitude to 9-bit signed, overflow forces full scale.
    function automatic logic signed [DW-1:0] form_d(input logic sgn, input logic ovf, input logic [7:0] mag);
        logic signed [8:0] d9;
        if (ovf) d9 = sgn ? 9'h100 : 9'h0FF;
        else     d9 = {sgn, mag};
        return DW'(d9);
    endfunction

    // Divide by 2^sh toward zero; wrap mode also limits a step to one lap.
    function automatic logic signed [DW-1:0] scale(input logic signed [DW-1:0] d, input logic [1:0] sh,
                                                   input logic signed [DW-1:0] max);
        logic signed [DW-1:0] mag, r;
        mag = d[DW-1] ? -d : d;
        mag = mag >>> sh;
        r   = d[DW-1] ? -mag : mag;
        if (WRAP_MODE != 0) begin
            if (r > max)       r = max;
            else if (r < -max) r = -max;
        end
        return r;
    endfunction

    function automatic logic [COORD_W-1:0] move(input logic [COORD_W-1:0] pos, input logic signed [DW-1:0] d,
                                                input logic signed [DW-1:0] lim, input logic signed [DW-1:0] max);
        logic signed [DW-1:0] n;
        n = $signed({2'b00, pos}) + d;
        if (WRAP_MODE != 0) begin
            if (n[DW-1])      n = n + lim;
            else if (n >= lim) n = n - lim;
        end else begin
            if (n[DW-1])      n = '0;
            else if (n > max) n = max;
        end
        return COORD_W'(n);
    endfunction

    always_comb begin
        pkt_in        = '0;
        pkt_in.status = PKT_STATUS;
        pkt_in.dx     = PKT_DX;
        pkt_in.dy     = PKT_DY;
`ifdef MOUSE_WHEEL_EN
        pkt_in.dz     = PKT_DZ;
`endif
    end

    assign PKT_READY = (count != (AW+1)'(FIFO_DEPTH));
    assign push_c    = PKT_VALID & PKT_READY;
    assign drop_c    = PKT_VALID & ~PKT_READY;
    assign upd_c     = (state_q == UPDATE);

    always_ff @(posedge CLK) begin
        if (push_c) mem[wr_ptr] <= pkt_in;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            if (push_c && !pop_c)      count <= count + (AW+1)'(1);
            else if (!push_c && pop_c) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: if (count != '0) begin
                pop_c   = 1'b1;
                state_d = LOAD;
            end
            LOAD:    state_d = CALC;
            CALC:    state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Delta pipeline: dx_q/dy_q hold the raw delta after LOAD, the scaled delta after CALC.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pkt_q <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
        end else begin
            if (pop_c) pkt_q <= mem[rd_ptr];
            if (state_q == LOAD) begin
                dx_q <= form_d(pkt_q.status[4], pkt_q.status[6], pkt_q.dx);
                dy_q <= form_d(pkt_q.status[5], pkt_q.status[7], pkt_q.dy);
            end else if (state_q == CALC) begin
                dx_q <= scale(dx_q, sens_q, X_MAX);
                dy_q <= scale(dy_q, sens_q, Y_MAX);
            end
        end
    end

    assign off_c      = BUS_ADDR[3:0];
    assign hit_c      = (BUS_ADDR[7:4] == BASE_ADDR[7:4]);
    assign ctrl_wr_c  = hit_c & BUS_WE & (off_c == 4'd5);
    assign recenter_c = ctrl_wr_c & BUS_DATA[2];
    assign ovf_clr_c  = ctrl_wr_c & BUS_DATA[3];
    assign unused_bus_hi = ^BUS_DATA[7:4];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MOUSE_X               <= X_CTR;
            MOUSE_Y               <= Y_CTR;
            MOUSE_STATUS          <= '0;
            MOUSE_INTERRUPT_RAISE <= 1'b0;
            sens_q                <= '0;
            ovf_q                 <= 1'b0;
        end else begin
            if (recenter_c) begin
                MOUSE_X <= X_CTR;
                MOUSE_Y <= Y_CTR;
            end else if (upd_c) begin
                MOUSE_X <= move(MOUSE_X, dx_q, X_LIM, X_MAX);
                MOUSE_Y <= move(MOUSE_Y, dy_q, Y_LIM, Y_MAX);
            end
            if (upd_c) MOUSE_STATUS <= pkt_q.status[3:0];
            if (upd_c)                    MOUSE_INTERRUPT_RAISE <= 1'b1;
            else if (MOUSE_INTERRUPT_ACK) MOUSE_INTERRUPT_RAISE <= 1'b0;
            if (ctrl_wr_c) sens_q <= BUS_DATA[1:0];
            if (drop_c)         ovf_q <= 1'b1;
            else if (ovf_clr_c) ovf_q <= 1'b0;
        end
    end

`ifdef MOUSE_WHEEL_EN
    logic signed [7:0] wheel_q;
    logic              wheel_clr_c;
    logic signed [8:0] wheel_sum_c;

    assign wheel_clr_c = hit_c & ~BUS_WE & (off_c == 4'd6);
    assign wheel_sum_c = {wheel_clr_c ? 1'b0 : wheel_q[7], wheel_clr_c ? 8'h00 : wheel_q}
                       + {pkt_q.dz[7], pkt_q.dz};
    assign wheel_val_c = wheel_q;

    // Saturating accumulate; a read-clear in the same cycle as an update keeps the new delta.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)          wheel_q <= '0;
        else if (upd_c) begin
            if (wheel_sum_c[8] != wheel_sum_c[7]) wheel_q <= wheel_sum_c[8] ? 8'sh80 : 8'sh7F;
            else                                  wheel_q <= wheel_sum_c[7:0];
        end else if (wheel_clr_c) wheel_q <= '0;
    end
`else
    logic unused_dz;
    assign unused_dz   = ^PKT_DZ;
    assign wheel_val_c = 8'h00;
`endif

    assign y_bus_c = (Y_INVERT != 0) ? COORD_W'(LIMIT_Y - 1) - MOUSE_Y : MOUSE_Y;

    always_comb begin
        rd_mux_c = 8'h00;
        case (off_c)
            4'd0: rd_mux_c = {ovf_q, 3'b000, MOUSE_STATUS};
            4'd1: rd_mux_c = 8'(MOUSE_X);
            4'd2: rd_mux_c = 8'(MOUSE_X >> 8);
            4'd3: rd_mux_c = 8'(y_bus_c);
            4'd4: rd_mux_c = 8'(y_bus_c >> 8);
            4'd5: rd_mux_c = {6'b000000, sens_q};
            4'd6: rd_mux_c = wheel_val_c;
            default: rd_mux_c = 8'h00;
        endcase
    end

    // Registered read port; released whenever a master is writing.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_en_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_en_q   <= hit_c & ~BUS_WE;
            rd_data_q <= rd_mux_c;
        end
    end

    assign BUS_DATA = (rd_en_q && !BUS_WE) ? rd_data_q : 8'hzz;
endmodule

// File: tb/tb_mouse_tracker_bus.sv
// Bench for mouse_tracker_bus: clamp and wrap instances driven together, checked against an arithmetic model.
module tb_mouse_tracker_bus;
    localparam int LX = 160;
    localparam int LY = 120;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pkt_valid = 1'b0, bus_we = 1'b0, ack = 1'b0, bus_drv = 1'b0;
    logic [7:0] pkt_status = '0, pkt_dx = '0, pkt_dy = '0, pkt_dz = '0;
    logic [7:0] bus_addr = '0, bus_wdata = '0;
    wire  [7:0] bus_data, bus_data_w;
    logic ready, ready_w, raise, raise_w;
    logic [9:0] mx, my, mx_w, my_w;
    logic [3:0] mstat, mstat_w;

    int total = 0;
    int bad = 0;
    int m_x, m_y, w_x, w_y, m_shift;
    logic [3:0] m_stat;

    always #5 clk = ~clk;

    assign bus_data   = bus_drv ? bus_wdata : 8'hzz;
    assign bus_data_w = bus_drv ? bus_wdata : 8'hzz;

    mouse_tracker_bus dut (
        .CLK(clk), .RESET_N(rst_n), .PKT_VALID(pkt_valid), .PKT_READY(ready),
        .PKT_STATUS(pkt_status), .PKT_DX(pkt_dx), .PKT_DY(pkt_dy), .PKT_DZ(pkt_dz),
        .BUS_ADDR(bus_addr), .BUS_DATA(bus_data), .BUS_WE(bus_we),
        .MOUSE_X(mx), .MOUSE_Y(my), .MOUSE_STATUS(mstat),
        .MOUSE_INTERRUPT_RAISE(raise), .MOUSE_INTERRUPT_ACK(ack));

    mouse_tracker_bus #(.WRAP_MODE(1)) dut_w (
        .CLK(clk), .RESET_N(rst_n), .PKT_VALID(pkt_valid), .PKT_READY(ready_w),
        .PKT_STATUS(pkt_status), .PKT_DX(pkt_dx), .PKT_DY(pkt_dy), .PKT_DZ(pkt_dz),
        .BUS_ADDR(bus_addr), .BUS_DATA(bus_data_w), .BUS_WE(bus_we),
        .MOUSE_X(mx_w), .MOUSE_Y(my_w), .MOUSE_STATUS(mstat_w),
        .MOUSE_INTERRUPT_RAISE(raise_w), .MOUSE_INTERRUPT_ACK(ack));

    // One axis of one packet, straight from the movement rules.
    function automatic int axis(input int pos, input bit sgn, input bit ovf, input int mag,
                                input int sh, input int lim, input bit wrap);
        int d, n;
        if (ovf) d = sgn ? -256 : 255;
        else     d = sgn ? mag - 256 : mag;
        d = d / (1 << sh);
        if (wrap) begin
            if (d > lim - 1)    d = lim - 1;
            if (d < -(lim - 1)) d = -(lim - 1);
        end
        n = pos + d;
        if (wrap) begin
            if (n < 0)         n = n + lim;
            else if (n >= lim) n = n - lim;
        end else begin
            if (n < 0)           n = 0;
            else if (n > lim - 1) n = lim - 1;
        end
        return n;
    endfunction

    task automatic model_pkt(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy);
        m_x = axis(m_x, st[4], st[6], int'(dx), m_shift, LX, 1'b0);
        m_y = axis(m_y, st[5], st[7], int'(dy), m_shift, LY, 1'b0);
        w_x = axis(w_x, st[4], st[6], int'(dx), m_shift, LX, 1'b1);
        w_y = axis(w_y, st[5], st[7], int'(dy), m_shift, LY, 1'b1);
        m_stat = st[3:0];
    endtask

    task automatic model_center();
        m_x = LX / 2; m_y = LY / 2; w_x = LX / 2; w_y = LY / 2;
    endtask

    function automatic logic [43:0] model_vec();
        return {10'(m_x), 10'(m_y), 10'(w_x), 10'(w_y), m_stat};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy);
        pkt_valid = 1'b1; pkt_status = st; pkt_dx = dx; pkt_dy = dy; pkt_dz = 8'($urandom);
        tick();
        pkt_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [7:0] d);
        bus_addr = {4'hA, off}; bus_we = 1'b0;
        tick();
        d = bus_data;
        bus_addr = 8'h00;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [7:0] v);
        bus_addr = {4'hA, off}; bus_we = 1'b1; bus_drv = 1'b1; bus_wdata = v;
        tick();
        bus_we = 1'b0; bus_drv = 1'b0; bus_addr = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        model_center(); m_shift = 0; m_stat = 4'h0;
        total++; if ({mx, my} !== {10'd80, 10'd60}) begin bad++; $display("FAIL reset_xy: got %0d,%0d want 80,60", mx, my); end
        total++; if ({raise, ready, mstat} !== {1'b0, 1'b1, 4'h0}) begin bad++; $display("FAIL reset_flags: got raise=%b ready=%b status=%h", raise, ready, mstat); end
        bus_read(4'd1, d);
        total++; if (d !== 8'h50) begin bad++; $display("FAIL reset_rd_x: got %h want 50", d); end
        bus_read(4'd3, d);
        total++; if (d !== 8'h3B) begin bad++; $display("FAIL reset_rd_y: got %h want 3b", d); end
        bus_read(4'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_rd_status: got %h want 00", d); end
        bus_read(4'd6, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_rd_wheel: got %h want 00", d); end
    endtask

    task automatic test_single_move();
        logic [7:0] d;
        push(8'h00, 8'd10, 8'd5);
        repeat (3) tick();
        total++; if ({mx, raise} !== {10'd80, 1'b0}) begin bad++; $display("FAIL latency_early: got x=%0d raise=%b want 80,0", mx, raise); end
        tick();
        model_pkt(8'h00, 8'd10, 8'd5);
        total++; if ({mx, my, raise} !== {10'd90, 10'd65, 1'b1}) begin bad++; $display("FAIL single_move: got %0d,%0d raise=%b want 90,65,1", mx, my, raise); end
        total++; if ({mx, my, mx_w, my_w, mstat} !== model_vec()) begin bad++; $display("FAIL single_model: got %h want %h", {mx, my, mx_w, my_w, mstat}, model_vec()); end
        ack = 1'b1; tick(); ack = 1'b0;
        total++; if (raise !== 1'b0) begin bad++; $display("FAIL ack_clear: got %b want 0", raise); end
        bus_read(4'd1, d);
        total++; if (d !== 8'(m_x)) begin bad++; $display("FAIL rd_x: got %h want %h", d, 8'(m_x)); end
        bus_read(4'd3, d);
        total++; if (d !== 8'(LY - 1 - m_y)) begin bad++; $display("FAIL rd_y_inv: got %h want %h", d, 8'(LY - 1 - m_y)); end
    endtask

    task automatic test_clamp_wrap();
        push(8'h50, 8'h00, 8'h00); repeat (5) tick(); model_pkt(8'h50, 8'h00, 8'h00);
        total++; if (mx !== 10'd0) begin bad++; $display("FAIL clamp_low: got %0d want 0", mx); end
        total++; if ({mx, my, mx_w, my_w, mstat} !== model_vec()) begin bad++; $display("FAIL clamp_low_model: got %h want %h", {mx, my, mx_w, my_w, mstat}, model_vec()); end
        push(8'h40, 8'h00, 8'h00); repeat (5) tick(); model_pkt(8'h40, 8'h00, 8'h00);
        total++; if (mx !== 10'd159) begin bad++; $display("FAIL clamp_high: got %0d want 159", mx); end
        bus_write(4'd5, 8'h04); m_shift = 0; model_center();
        total++; if ({mx, my, mx_w} !== {10'd80, 10'd60, 10'd80}) begin bad++; $display("FAIL recenter: got %0d,%0d,%0d want 80,60,80", mx, my, mx_w); end
        push(8'h00, 8'd70, 8'h00); repeat (5) tick(); model_pkt(8'h00, 8'd70, 8'h00);
        push(8'h00, 8'd20, 8'h00); repeat (5) tick(); model_pkt(8'h00, 8'd20, 8'h00);
        total++; if ({mx_w, mx} !== {10'd10, 10'd159}) begin bad++; $display("FAIL wrap_edge: got wrap=%0d clamp=%0d want 10,159", mx_w, mx); end
        total++; if ({mx, my, mx_w, my_w, mstat} !== model_vec()) begin bad++; $display("FAIL wrap_model: got %h want %h", {mx, my, mx_w, my_w, mstat}, model_vec()); end
    endtask

    task automatic test_shift();
        logic [7:0] d;
        int old;
        bus_write(4'd5, 8'h02); m_shift = 2;
        bus_read(4'd5, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL ctrl_rd: got %h want 02", d); end
        old = m_x;
        push(8'h10, 8'hF9, 8'h00); repeat (5) tick(); model_pkt(8'h10, 8'hF9, 8'h00);
        total++; if (mx !== 10'(old - 1)) begin bad++; $display("FAIL shift_minus7: got %0d want %0d", mx, old - 1); end
        total++; if ({mx, my, mx_w, my_w, mstat} !== model_vec()) begin bad++; $display("FAIL shift_model: got %h want %h", {mx, my, mx_w, my_w, mstat}, model_vec()); end
    endtask

    task automatic test_random();
        logic [7:0] st, dx, dy;
        int v;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                v = $urandom_range(0, 3);
                if ($urandom_range(0, 2) == 0) begin
                    bus_write(4'd5, 8'(v) | 8'h04); model_center();
                end else begin
                    bus_write(4'd5, 8'(v));
                end
                m_shift = v;
            end
            st = 8'($urandom); dx = 8'($urandom); dy = 8'($urandom);
            push(st, dx, dy);
            repeat (4) tick();
            model_pkt(st, dx, dy);
            total++; if ({mx, my, mx_w, my_w, mstat, raise} !== {model_vec(), 1'b1}) begin bad++; $display("FAIL random_%0d: got %h want %h", i, {mx, my, mx_w, my_w, mstat, raise}, {model_vec(), 1'b1}); end
            ack = 1'b1; tick(); ack = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [23:0] q[$];
        logic acc;
        int n_acc = 0;
        bit dropped = 0;
        for (int i = 0; i < 12 && !dropped; i++) begin
            pkt_valid = 1'b1; pkt_status = 8'($urandom); pkt_dx = 8'($urandom); pkt_dy = 8'($urandom);
            acc = ready;
            if (acc) q.push_back({pkt_status, pkt_dx, pkt_dy});
            tick();
            if (acc) n_acc++;
            else     dropped = 1;
        end
        pkt_valid = 1'b0;
        // The first packet leaves the FIFO for the FSM one edge after entering, so one extra fits.
        total++; if (n_acc !== DEPTH + 1 || !dropped) begin bad++; $display("FAIL fifo_full: got accepted=%0d dropped=%0d want %0d,1", n_acc, dropped, DEPTH + 1); end
        repeat (30) tick();
        foreach (q[k]) model_pkt(q[k][23:16], q[k][15:8], q[k][7:0]);
        total++; if ({mx, my, mx_w, my_w, mstat} !== model_vec()) begin bad++; $display("FAIL b2b_model: got %h want %h", {mx, my, mx_w, my_w, mstat}, model_vec()); end
        bus_read(4'd0, d);
        total++; if (d !== {1'b1, 3'b000, m_stat}) begin bad++; $display("FAIL ovf_set: got %h want %h", d, {1'b1, 3'b000, m_stat}); end
        bus_write(4'd5, 8'h08); m_shift = 0;
        bus_read(4'd0, d);
        total++; if (d !== {1'b0, 3'b000, m_stat}) begin bad++; $display("FAIL ovf_clear: got %h want %h", d, {1'b0, 3'b000, m_stat}); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        bus_write(4'd5, 8'h04); m_shift = 0; model_center();
        push(8'h03, 8'd5, 8'd2); repeat (5) tick(); model_pkt(8'h03, 8'd5, 8'd2);
        ack = 1'b1; tick(); ack = 1'b0;
        total++; if ({mx, my, mstat} !== {10'd85, 10'd62, 4'h3}) begin bad++; $display("FAIL pre_reset: got %0d,%0d,%h want 85,62,3", mx, my, mstat); end
        push(8'h01, 8'd30, 8'd30);
        push(8'h02, 8'd40, 8'd40);
        tick();
        rst_n = 1'b0;
        #1;
        total++; if ({mx, my, mstat, raise, ready} !== {10'd80, 10'd60, 4'h0, 1'b0, 1'b1}) begin bad++; $display("FAIL reset_async: got %0d,%0d st=%h raise=%b ready=%b", mx, my, mstat, raise, ready); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        total++; if ({mx, my, mx_w, raise} !== {10'd80, 10'd60, 10'd80, 1'b0}) begin bad++; $display("FAIL reset_flush: got %0d,%0d,%0d raise=%b", mx, my, mx_w, raise); end
        bus_read(4'd5, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_shift: got %h want 00", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_move();
        test_clamp_wrap();
        test_shift();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
